// File: rtl/jtag_fir_config_top.sv
// JTAG-style configuration front end for the FIR filter register file.
// A 1149.1 TAP controller loads a 4-bit IR; under CONFIG, 8-bit DR scans
// first arm the block with a sync word, then write successive filter registers.
module jtag_fir_config_top #(
    parameter int unsigned    IR_W      = 4,
    parameter int unsigned    DR_W      = 8,
    parameter logic [DR_W-1:0] SYNC_WORD = 8'hF0,
    parameter logic [IR_W-1:0] CFG_INSTR = 4'b0100
) (
    input  logic            iTck,
    input  logic            iTrst,
    input  logic            iTms,
    input  logic            iTdi,
    input  logic            iDesync,
    output logic            oRINC,
    output logic            WrEn,
    output logic [2:0]      regAddr,
    output logic [DR_W-1:0] D7_D0,
    output logic [DR_W-1:0] setDataReg_Latch
);

    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
    } tap_e;

    tap_e            tap_q, tap_d;
    logic [IR_W-1:0] ir_q, ir_sh_q;
    logic [DR_W-1:0] dr_sh_q;
    logic            synced_q;
    logic [2:0]      reg_addr_q;
    logic            wr_en_q, rinc_q;
    logic [DR_W-1:0] data_q, latch_q;
    logic            cfg_sel;

    assign cfg_sel = (ir_q == CFG_INSTR);

    // Standard 1149.1 TAP transition function on TMS
    always_comb begin
        tap_d = tap_q;
        case (tap_q)
            TLR:      tap_d = iTms ? TLR      : RTI;
            RTI:      tap_d = iTms ? SEL_DR   : RTI;
            SEL_DR:   tap_d = iTms ? SEL_IR   : CAP_DR;
            CAP_DR:   tap_d = iTms ? EX1_DR   : SH_DR;
            SH_DR:    tap_d = iTms ? EX1_DR   : SH_DR;
            EX1_DR:   tap_d = iTms ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: tap_d = iTms ? EX2_DR   : PAUSE_DR;
            EX2_DR:   tap_d = iTms ? UPD_DR   : SH_DR;
            UPD_DR:   tap_d = iTms ? SEL_DR   : RTI;
            SEL_IR:   tap_d = iTms ? TLR      : CAP_IR;
            CAP_IR:   tap_d = iTms ? EX1_IR   : SH_IR;
            SH_IR:    tap_d = iTms ? EX1_IR   : SH_IR;
            EX1_IR:   tap_d = iTms ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: tap_d = iTms ? EX2_IR   : PAUSE_IR;
            EX2_IR:   tap_d = iTms ? UPD_IR   : SH_IR;
            UPD_IR:   tap_d = iTms ? SEL_DR   : RTI;
            default:  tap_d = TLR;
        endcase
    end

    // TAP state, IR/DR shifting, sync tracking and register-file write sequencing
    always_ff @(posedge iTck) begin
        if (iTrst) begin
            tap_q      <= TLR;
            ir_q       <= '1;
            ir_sh_q    <= '0;
            dr_sh_q    <= '0;
            synced_q   <= 1'b0;
            reg_addr_q <= 3'd0;
            wr_en_q    <= 1'b0;
            rinc_q     <= 1'b0;
            data_q     <= '0;
            latch_q    <= '0;
        end else begin
            tap_q   <= tap_d;
            wr_en_q <= 1'b0;
            rinc_q  <= 1'b0;

            case (tap_q)
                TLR:    ir_q    <= '1;
                CAP_IR: ir_sh_q <= IR_W'(1);
                SH_IR:  ir_sh_q <= {iTdi, ir_sh_q[IR_W-1:1]};
                UPD_IR: ir_q    <= ir_sh_q;
                SH_DR:  if (cfg_sel) dr_sh_q <= {iTdi, dr_sh_q[DR_W-1:1]};
                default: ;
            endcase

            // Desync overrides both a pending increment and a same-cycle write
            if (iDesync) begin
                synced_q   <= 1'b0;
                reg_addr_q <= 3'd0;
            end else begin
                // Address advances the cycle after each write strobe
                if (wr_en_q) begin
                    reg_addr_q <= reg_addr_q + 3'd1;
                    rinc_q     <= 1'b1;
                end
                if (tap_q == UPD_DR && cfg_sel) begin
                    if (synced_q) begin
                        wr_en_q <= 1'b1;
                        data_q  <= dr_sh_q;
                        latch_q <= dr_sh_q;
                    end else if (dr_sh_q == SYNC_WORD) begin
                        synced_q   <= 1'b1;
                        reg_addr_q <= 3'd0;
                    end
                end
            end
        end
    end

    assign oRINC            = rinc_q;
    assign WrEn             = wr_en_q;
    assign regAddr          = reg_addr_q;
    assign D7_D0            = data_q;
    assign setDataReg_Latch = latch_q;

endmodule

// File: tb/tb_jtag_fir_config_top.sv
// Directed table-driven bench for jtag_fir_config_top.
module tb_jtag_fir_config_top;

    logic       iTck = 1'b0;
    logic       iTrst = 1'b1;
    logic       iTms = 1'b1;
    logic       iTdi = 1'b0;
    logic       iDesync = 1'b0;
    logic       oRINC, WrEn;
    logic [2:0] regAddr;
    logic [7:0] D7_D0, setDataReg_Latch;

    int n_checks = 0;
    int n_fail   = 0;

    jtag_fir_config_top dut (
        .iTck(iTck), .iTrst(iTrst), .iTms(iTms), .iTdi(iTdi), .iDesync(iDesync),
        .oRINC(oRINC), .WrEn(WrEn), .regAddr(regAddr),
        .D7_D0(D7_D0), .setDataReg_Latch(setDataReg_Latch)
    );

    always #5 iTck = ~iTck;

    typedef struct {
        logic       pre_desync;
        logic       pause;
        logic       upd_desync;
        logic [7:0] data;
        logic       exp_wr;
        logic [7:0] exp_lat;
        logic [2:0] exp_addr;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One TCK cycle: drive on falling edge, sample 1 after rising edge
    task automatic step(input logic tms, input logic tdi);
        @(negedge iTck);
        iTms = tms;
        iTdi = tdi;
        @(posedge iTck);
        #1;
        check("wr_rinc_exclusive", 32'(WrEn & oRINC), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wren"},  32'(WrEn), 32'd0);
        check({tag, "_rinc"},  32'(oRINC), 32'd0);
        check({tag, "_addr"},  32'(regAddr), 32'd0);
        check({tag, "_d"},     32'(D7_D0), 32'd0);
        check({tag, "_latch"}, 32'(setDataReg_Latch), 32'd0);
    endtask

    // From RTI back to RTI, loading ir (b0 shifted first)
    task automatic ir_scan(input logic [3:0] ir);
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        for (int k = 0; k < 4; k++) step(k == 3, ir[k]);
        step(1, 0);
        step(0, 0);
    endtask

    // From RTI to RTI; reports outputs at update edge and the cycle after
    task automatic dr_scan(input logic [7:0] data, input logic pause, input logic upd_desync,
                           output logic wr, output logic [7:0] d, output logic [7:0] lat,
                           output logic rinc, output logic [2:0] addr);
        step(1, 0); step(0, 0); step(0, 0);
        for (int k = 0; k < 8; k++) begin
            step((k == 7) || (pause && k == 3), data[k]);
            if (pause && k == 3) begin
                step(0, 0); step(0, 0); step(1, 0); step(0, 0);
            end
        end
        step(1, 0);
        iDesync = upd_desync;
        step(0, 0);
        iDesync = 1'b0;
        wr  = WrEn;
        d   = D7_D0;
        lat = setDataReg_Latch;
        step(0, 0);
        rinc = oRINC;
        addr = regAddr;
    endtask

    initial begin
        logic       wr, rinc;
        logic [7:0] d, lat;
        logic [2:0] addr;

        //             pre upd? data    wr  latch   addr
        vecs[0] = '{1'b0, 1'b1, 1'b0, 8'hF0, 1'b0, 8'h00, 3'd0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 8'h01, 3'd1};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 8'hF0, 1'b1, 8'hF0, 3'd2};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 8'h02, 1'b0, 8'hF0, 3'd0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 8'hF0, 1'b0, 8'hF0, 3'd0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 8'h3C, 1'b1, 8'h3C, 3'd1};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 8'h77, 1'b0, 8'h3C, 3'd0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 8'h55, 1'b0, 8'h3C, 3'd0};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 8'hF0, 1'b0, 8'h3C, 3'd0};

        // Reset, then five TMS=1 keeps TLR
        step(1, 0); step(1, 0);
        check_all_zero("reset");
        iTrst = 1'b0;
        for (int k = 0; k < 5; k++) step(1, 0);
        check_all_zero("tlr");
        step(0, 0);

        // IR is BYPASS after reset: sync word plus data must not write
        dr_scan(8'hF0, 1'b0, 1'b0, wr, d, lat, rinc, addr);
        dr_scan(8'h01, 1'b0, 1'b0, wr, d, lat, rinc, addr);
        check("bypass_wren", 32'(wr), 32'd0);
        check("bypass_addr", 32'(addr), 32'd0);

        // Load CONFIG instruction (shift order 0,0,1,0)
        ir_scan(4'b0100);
        check("ir_load_wren", 32'(WrEn), 32'd0);

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].pre_desync) begin
                iDesync = 1'b1;
                step(0, 0);
                iDesync = 1'b0;
                check($sformatf("v%0d_desync_addr", i), 32'(regAddr), 32'd0);
            end
            dr_scan(vecs[i].data, vecs[i].pause, vecs[i].upd_desync, wr, d, lat, rinc, addr);
            check($sformatf("v%0d_wren", i),  32'(wr), 32'(vecs[i].exp_wr));
            check($sformatf("v%0d_d", i),     32'(d), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d_latch", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d_rinc", i),  32'(rinc), 32'(vecs[i].exp_wr));
            check($sformatf("v%0d_addr", i),  32'(addr), 32'(vecs[i].exp_addr));
        end

        // Synced from vecs[8]: 255 writes, address wraps 7->0
        for (int i = 1; i < 256; i++) begin
            dr_scan(8'(i), 1'b0, 1'b0, wr, d, lat, rinc, addr);
            check($sformatf("w%0d_wren", i), 32'(wr), 32'd1);
            check($sformatf("w%0d_d", i),    32'(d), 32'(i));
            check($sformatf("w%0d_rinc", i), 32'(rinc), 32'd1);
            check($sformatf("w%0d_addr", i), 32'(addr), 32'(i % 8));
        end
        check("pre_reset_latch", 32'(setDataReg_Latch), 32'hFF);

        // Reset mid Shift-DR discards the scan and the sync
        step(1, 0); step(0, 0); step(0, 0);
        for (int k = 0; k < 4; k++) step(0, 1);
        iTrst = 1'b1;
        step(0, 0);
        iTrst = 1'b0;
        check_all_zero("midscan_reset");
        step(0, 0);
        ir_scan(4'b0100);
        dr_scan(8'h33, 1'b0, 1'b0, wr, d, lat, rinc, addr);
        check("post_reset_wren", 32'(wr), 32'd0);
        check("post_reset_latch", 32'(lat), 32'd0);
        check("post_reset_rinc", 32'(rinc), 32'd0);
        check("post_reset_addr", 32'(addr), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
